// File: rtl/ledr_sequencer.sv
// Avalon-MM LED pattern engine: static, blink and rotate modes on the red LEDs,
// with a sticky wrap flag and an optional level interrupt.
`timescale 1ns/1ps
module ledr_sequencer #(
  parameter int WIDTH    = 18,
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [WIDTH-1:0]    out_port,
  output logic                irq
);

  localparam int STEP_W = $clog2(WIDTH);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIDTH - 1);

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_ROTL   = 2'd2;
  localparam logic [1:0] MODE_ROTR   = 2'd3;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
    return {v[0], v[WIDTH-1:1]};
  endfunction

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [1:0]          mode_q, mode_d;
  logic                en_q, en_d;
  logic                irq_en_q, irq_en_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                wrap_q, wrap_d;
  logic [WIDTH-1:0]    shadow_q, shadow_d;
  logic [PERIOD_W-1:0] presc_q, presc_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                phase_q, phase_d;
  logic [WIDTH-1:0]    out_port_q;
  logic                irq_q;

  logic wr_s, wrap_set_s, wrap_clr_s, run_req_s, tick_s;
  logic [PERIOD_W-1:0] presc_next_s;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:WIDTH];

  // Register writes, FSM next state and pattern engine.
  always_comb begin
    wr_s       = chipselect & ~write_n;
    data_d     = data_q;
    mode_d     = mode_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    period_d   = period_q;
    wrap_clr_s = 1'b0;
    wrap_set_s = 1'b0;
    state_d    = state_q;
    shadow_d   = shadow_q;
    presc_d    = presc_q;
    step_d     = step_q;
    phase_d    = phase_q;

    if (wr_s) begin
      case (address)
        ADDR_DATA:   data_d     = writedata[WIDTH-1:0];
        ADDR_CTRL:   begin
          mode_d   = writedata[1:0];
          en_d     = writedata[2];
          irq_en_d = writedata[3];
        end
        ADDR_PERIOD: period_d   = writedata[PERIOD_W-1:0];
        ADDR_STATUS: wrap_clr_s = writedata[0];
        default:     wrap_clr_s = 1'b0;
      endcase
    end else begin
      wrap_clr_s = 1'b0;
    end

    run_req_s    = en_d & (mode_d != MODE_STATIC);
    tick_s       = (presc_q == {PERIOD_W{1'b0}});
    presc_next_s = tick_s ? period_q : (presc_q - {{(PERIOD_W-1){1'b0}}, 1'b1});

    case (state_q)
      IDLE: begin
        shadow_d = data_d;
        step_d   = {STEP_W{1'b0}};
        phase_d  = 1'b0;
        if (run_req_s) begin
          state_d = RUN;
          presc_d = period_q;
        end else begin
          presc_d = {PERIOD_W{1'b0}};
        end
      end
      RUN: begin
        if (!run_req_s) begin
          state_d  = IDLE;
          shadow_d = data_d;
          presc_d  = {PERIOD_W{1'b0}};
          step_d   = {STEP_W{1'b0}};
          phase_d  = 1'b0;
        end else if (wr_s && (address == ADDR_CTRL) && (mode_d != mode_q)) begin
          shadow_d = data_d;
          presc_d  = period_q;
          step_d   = {STEP_W{1'b0}};
          phase_d  = 1'b0;
        end else if (wr_s && (address == ADDR_DATA)) begin
          // New pattern restarts the sequence but keeps the tick cadence.
          shadow_d = data_d;
          presc_d  = presc_next_s;
          step_d   = {STEP_W{1'b0}};
          phase_d  = 1'b0;
        end else begin
          presc_d = presc_next_s;
          if (tick_s) begin
            case (mode_q)
              MODE_BLINK: begin
                phase_d    = ~phase_q;
                shadow_d   = phase_q ? data_q : {WIDTH{1'b0}};
                wrap_set_s = phase_q;
              end
              MODE_ROTL, MODE_ROTR: begin
                shadow_d   = (mode_q == MODE_ROTL) ? rot_left(shadow_q) : rot_right(shadow_q);
                wrap_set_s = (step_q == STEP_LAST);
                step_d     = (step_q == STEP_LAST) ? {STEP_W{1'b0}} : step_q + {{(STEP_W-1){1'b0}}, 1'b1};
              end
              default: shadow_d = shadow_q;
            endcase
          end else begin
            shadow_d = shadow_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A wrap raised by a tick outranks a simultaneous software clear.
    if (wrap_set_s) begin
      wrap_d = 1'b1;
    end else if (wrap_clr_s) begin
      wrap_d = 1'b0;
    end else begin
      wrap_d = wrap_q;
    end
  end

  // State, register file and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      data_q     <= {WIDTH{1'b0}};
      mode_q     <= 2'd0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      period_q   <= {PERIOD_W{1'b0}};
      wrap_q     <= 1'b0;
      shadow_q   <= {WIDTH{1'b0}};
      presc_q    <= {PERIOD_W{1'b0}};
      step_q     <= {STEP_W{1'b0}};
      phase_q    <= 1'b0;
      out_port_q <= {WIDTH{1'b0}};
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      period_q   <= period_d;
      wrap_q     <= wrap_d;
      shadow_q   <= shadow_d;
      presc_q    <= presc_d;
      step_q     <= step_d;
      phase_q    <= phase_d;
      out_port_q <= shadow_q;
      irq_q      <= wrap_q & irq_en_q;
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]    = data_q;
      ADDR_CTRL:   readdata[3:0]          = {irq_en_q, en_q, mode_q};
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = period_q;
      ADDR_STATUS: readdata[1:0]          = {(state_q == RUN), wrap_q};
      default:     readdata               = 32'd0;
    endcase
  end

  assign out_port = out_port_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_ledr_sequencer.sv
// Directed bench for ledr_sequencer: register access, rotate/blink patterns,
// mid-run reloads, wrap/irq handling and asynchronous reset.
`timescale 1ns/1ps
module tb_ledr_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [17:0] out_port;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] rv;
  logic [17:0] exp_led, old_led;

  ledr_sequencer #(.WIDTH(18), .PERIOD_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
    address = 3'd0;
  endtask

  initial begin
    // Reset state
    #2;
    check_val("rst_out", {14'd0, out_port}, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    check_val("rst_rdata", readdata, 32'd0);
    #10 reset_n = 1'b1;
    cyc(1);

    // DATA write and readback in IDLE
    wr(3'd0, 32'h0002A5A5);
    check_val("idle_out_pre", {14'd0, out_port}, 32'd0);
    rd(3'd0, rv); check_val("data_rd", rv, 32'h0002A5A5);
    cyc(1);
    check_val("idle_out", {14'd0, out_port}, 32'h0002A5A5);
    wr(3'd5, 32'hFFFFFFFF);
    rd(3'd5, rv); check_val("addr5_rd", rv, 32'd0);

    // Rotate-left, PERIOD=3: one step every 4 cycles, wrap after 18 ticks
    wr(3'd0, 32'h1);
    wr(3'd2, 32'd3);
    wr(3'd1, 32'h6);
    rd(3'd1, rv); check_val("ctrl_rd", rv, 32'h6);
    cyc(1);
    exp_led = 18'h00001;
    for (int k = 1; k <= 18; k++) begin
      old_led = exp_led;
      exp_led = {exp_led[16:0], exp_led[17]};
      cyc(3);
      check_val($sformatf("rotl_hold%0d", k), {14'd0, out_port}, {14'd0, old_led});
      cyc(1);
      check_val($sformatf("rotl_step%0d", k), {14'd0, out_port}, {14'd0, exp_led});
    end
    check_val("rotl_final", {14'd0, out_port}, 32'h1);
    rd(3'd3, rv); check_val("rotl_status", rv, 32'h3);
    wr(3'd1, 32'h0);
    wr(3'd3, 32'h1);
    rd(3'd3, rv); check_val("status_clr", rv, 32'h0);

    // Blink every cycle with irq
    wr(3'd0, 32'h3FFFF);
    wr(3'd2, 32'd0);
    wr(3'd1, 32'hD);
    cyc(1); check_val("blink_1", {14'd0, out_port}, 32'h3FFFF);
    cyc(1); check_val("blink_2", {14'd0, out_port}, 32'h0);
    check_val("blink_irq_lo", {31'd0, irq}, 32'd0);
    cyc(1); check_val("blink_3", {14'd0, out_port}, 32'h3FFFF);
    check_val("blink_irq_hi", {31'd0, irq}, 32'd1);
    cyc(1); check_val("blink_4", {14'd0, out_port}, 32'h0);
    wr(3'd3, 32'h1);
    check_val("irq_clr_lag", {31'd0, irq}, 32'd1);
    rd(3'd3, rv); check_val("wrap_cleared", rv, 32'h2);
    cyc(1); check_val("irq_dropped", {31'd0, irq}, 32'd0);
    cyc(1); check_val("irq_reassert", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'h1);
    rd(3'd3, rv); check_val("set_wins", rv, 32'h3);
    cyc(1); check_val("irq_kept", {31'd0, irq}, 32'd1);
    wr(3'd1, 32'h0);
    wr(3'd3, 32'h1);
    cyc(1); check_val("irq_off", {31'd0, irq}, 32'd0);

    // Rotate-right with a DATA reload mid-sequence
    wr(3'd0, 32'h1);
    wr(3'd2, 32'd1);
    wr(3'd1, 32'h7);
    cyc(10);
    wr(3'd0, 32'h20000);
    rd(3'd3, rv); check_val("rotr_running", rv, 32'h2);
    cyc(2); check_val("rotr_first", {14'd0, out_port}, 32'h10000);
    cyc(32);
    rd(3'd3, rv); check_val("rotr_no_early_wrap", rv, 32'h2);
    cyc(1);
    rd(3'd3, rv); check_val("rotr_wrap", rv, 32'h3);
    cyc(1); check_val("rotr_back", {14'd0, out_port}, 32'h20000);
    wr(3'd1, 32'h0);
    wr(3'd3, 32'h1);

    // PERIOD change applies at the next reload
    wr(3'd0, 32'h1);
    wr(3'd2, 32'd100);
    wr(3'd1, 32'h6);
    wr(3'd2, 32'd1);
    cyc(100); check_val("p100_hold", {14'd0, out_port}, 32'h1);
    cyc(1); check_val("p100_tick", {14'd0, out_port}, 32'h2);
    cyc(1); check_val("p1_hold", {14'd0, out_port}, 32'h2);
    cyc(1); check_val("p1_tick1", {14'd0, out_port}, 32'h4);
    cyc(2); check_val("p1_tick2", {14'd0, out_port}, 32'h8);

    // Mode change restarts, then asynchronous reset mid-run
    wr(3'd2, 32'd0);
    wr(3'd1, 32'hD);
    cyc(5);
    check_val("restart_irq", {31'd0, irq}, 32'd1);
    check_val("restart_out", {14'd0, out_port}, 32'h1);
    #3 reset_n = 1'b0;
    #1;
    check_val("arst_out", {14'd0, out_port}, 32'd0);
    check_val("arst_irq", {31'd0, irq}, 32'd0);
    rd(3'd3, rv); check_val("arst_status", rv, 32'd0);
    rd(3'd1, rv); check_val("arst_ctrl", rv, 32'd0);
    #2 reset_n = 1'b1;
    cyc(2);
    check_val("post_rst_out", {14'd0, out_port}, 32'd0);
    rd(3'd1, rv); check_val("post_rst_ctrl", rv, 32'd0);
    rd(3'd0, rv); check_val("post_rst_data", rv, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
